// File: rtl/gd_iter_ctrl.sv
// rtl/gd_iter_ctrl.sv - iteration sequencer for the 4-variable gradient-descent step datapath
//
// Loads an initial point, launches one gradient step at a time and applies the
// returned Q8.8 diffs with saturating subtraction. A run stops on convergence,
// the iteration limit, a datapath overflow or a step timeout. It then reports
// the final point, the function value and a status code.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           begin a run (sampled only when idle)
//   a_init..d_init [15:0]           signed Q8.8 initial point
//   busy                            high whenever not idle
//   done                            one-cycle pulse at the end of a run
//   status [1:0]                    00 converged, 01 max-iter, 10 overflow, 11 timeout
//   iter_count [15:0]               applied steps in the current/last run
//   a_res..d_res [15:0]             current point (signed Q8.8)
//   value_res [31:0]                function value from the last accepted step (Q24.8)
//   step_start                      one-cycle launch pulse to the step block
//   step_a..step_d [15:0]           step operands (the current point)
//   step_value [31:0]               Q24.8 value returned by the step block
//   step_a_diff..step_d_diff [15:0] signed Q8.8 diffs returned by the step block
//   step_done                       one-cycle result-valid pulse
//   step_overflow                   overflow flag, qualified by step_done

module gd_iter_ctrl #(
  parameter logic [15:0] MAX_ITER = 16'd256,
  parameter logic [15:0] TOL      = 16'h0001,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a_init,
  input  logic [15:0] b_init,
  input  logic [15:0] c_init,
  input  logic [15:0] d_init,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] iter_count,
  output logic [15:0] a_res,
  output logic [15:0] b_res,
  output logic [15:0] c_res,
  output logic [15:0] d_res,
  output logic [31:0] value_res,
  output logic        step_start,
  output logic [15:0] step_a,
  output logic [15:0] step_b,
  output logic [15:0] step_c,
  output logic [15:0] step_d,
  input  logic [31:0] step_value,
  input  logic [15:0] step_a_diff,
  input  logic [15:0] step_b_diff,
  input  logic [15:0] step_c_diff,
  input  logic [15:0] step_d_diff,
  input  logic        step_done,
  input  logic        step_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP_REQ, S_STEP_WAIT, S_UPDATE, S_CHECK, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] a_diff, b_diff, c_diff, d_diff;
  logic [15:0] timer;
  logic [15:0] timer_inc;
  logic        timeout_hit;
  logic        converged;

  // x - d in 17 bits; bits 16 and 15 differ exactly when the result leaves the
  // 16-bit range, and bit 16 then tells which rail to clamp to.
  function automatic logic [15:0] sat_sub(input logic [15:0] x, input logic [15:0] d);
    logic [16:0] r;
    r = {x[15], x} - {d[15], d};
    if (r[16] != r[15]) return r[16] ? 16'h8000 : 16'h7FFF;
    return r[15:0];
  endfunction

  // Magnitude is taken in 17 bits so that 0x8000 becomes +32768, not -32768.
  function automatic logic within_tol(input logic [15:0] d);
    logic [16:0] m;
    m = d[15] ? (17'd0 - {1'b1, d}) : {1'b0, d};
    return m <= {1'b0, TOL};
  endfunction

  assign converged = within_tol(a_diff) && within_tol(b_diff) &&
                     within_tol(c_diff) && within_tol(d_diff);

  // timer holds the number of STEP_WAIT cycles already elapsed. Leaving on
  // timer+1 == TIMEOUT-1 makes done land exactly TIMEOUT cycles after step_start.
  assign timer_inc   = timer + 16'd1;
  assign timeout_hit = (timer_inc == (TIMEOUT - 16'd1));

  assign step_a = a_res;
  assign step_b = b_res;
  assign step_c = c_res;
  assign step_d = d_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    step_start = 1'b0;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_STEP_REQ;
      S_STEP_REQ: begin
        step_start = 1'b1;
        state_nxt  = S_STEP_WAIT;
      end
      S_STEP_WAIT: begin
        if (step_done)        state_nxt = step_overflow ? S_DONE : S_UPDATE;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_UPDATE:    state_nxt = S_CHECK;
      S_CHECK: begin
        if (converged || iter_count == MAX_ITER) state_nxt = S_DONE;
        else                                     state_nxt = S_STEP_REQ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_res      <= 16'h0;
      b_res      <= 16'h0;
      c_res      <= 16'h0;
      d_res      <= 16'h0;
      a_diff     <= 16'h0;
      b_diff     <= 16'h0;
      c_diff     <= 16'h0;
      d_diff     <= 16'h0;
      value_res  <= 32'h0;
      status     <= 2'b00;
      iter_count <= 16'h0;
      timer      <= 16'h0;
    end else begin
      case (state)
        S_LOAD: begin
          a_res      <= a_init;
          b_res      <= b_init;
          c_res      <= c_init;
          d_res      <= d_init;
          iter_count <= 16'h0;
        end
        S_STEP_REQ: timer <= 16'h0;
        S_STEP_WAIT: begin
          timer <= timer_inc;
          if (step_done) begin
            if (step_overflow) begin
              status <= 2'b10;
            end else begin
              a_diff    <= step_a_diff;
              b_diff    <= step_b_diff;
              c_diff    <= step_c_diff;
              d_diff    <= step_d_diff;
              value_res <= step_value;
            end
          end else if (timeout_hit) begin
            status <= 2'b11;
          end
        end
        S_UPDATE: begin
          a_res      <= sat_sub(a_res, a_diff);
          b_res      <= sat_sub(b_res, b_diff);
          c_res      <= sat_sub(c_res, c_diff);
          d_res      <= sat_sub(d_res, d_diff);
          iter_count <= iter_count + 16'd1;
        end
        S_CHECK: begin
          if (converged)                    status <= 2'b00;
          else if (iter_count == MAX_ITER)  status <= 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// tb/tb_gd_iter_ctrl.sv - scoreboard bench for gd_iter_ctrl with a stub step block

module tb_gd_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_init = '0, b_init = '0, c_init = '0, d_init = '0;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] iter_count, a_res, b_res, c_res, d_res;
  logic [31:0] value_res;
  logic        step_start;
  logic [15:0] step_a, step_b, step_c, step_d;
  logic [31:0] step_value = '0;
  logic [15:0] step_a_diff = '0, step_b_diff = '0, step_c_diff = '0, step_d_diff = '0;
  logic        step_done = 1'b0, step_overflow = 1'b0;

  always #5 clk = ~clk;

  gd_iter_ctrl #(.MAX_ITER(16'd4), .TOL(16'h0001), .TIMEOUT(16'd64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
    .busy(busy), .done(done), .status(status), .iter_count(iter_count),
    .a_res(a_res), .b_res(b_res), .c_res(c_res), .d_res(d_res),
    .value_res(value_res), .step_start(step_start),
    .step_a(step_a), .step_b(step_b), .step_c(step_c), .step_d(step_d),
    .step_value(step_value),
    .step_a_diff(step_a_diff), .step_b_diff(step_b_diff),
    .step_c_diff(step_c_diff), .step_d_diff(step_d_diff),
    .step_done(step_done), .step_overflow(step_overflow)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] it, a, b, c, d;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Stub step block: answers each step_start after stub_lat cycles.
  int          stub_lat = 10;
  bit          stub_silent = 1'b0;
  int          stub_ovf_at = 0;
  int          stub_launches = 0;
  logic [15:0] sd_a = '0, sd_b = '0, sd_c = '0, sd_d = '0;
  logic [31:0] stub_val_base = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (step_start) begin
        stub_launches++;
        if (!stub_silent) begin
          repeat (stub_lat - 1) @(negedge clk);
          step_a_diff   = sd_a;
          step_b_diff   = sd_b;
          step_c_diff   = sd_c;
          step_d_diff   = sd_d;
          step_value    = stub_val_base + 32'(stub_launches);
          step_overflow = (stub_launches == stub_ovf_at);
          step_done     = 1'b1;
          @(negedge clk);
          step_done     = 1'b0;
          step_overflow = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no pending run");
      end else begin
        mon_e = sb_q.pop_front();
        check("status",     {30'd0, status},     {30'd0, mon_e.st});
        check("iter_count", {16'd0, iter_count}, {16'd0, mon_e.it});
        check("a_res",      {16'd0, a_res},      {16'd0, mon_e.a});
        check("b_res",      {16'd0, b_res},      {16'd0, mon_e.b});
        check("c_res",      {16'd0, c_res},      {16'd0, mon_e.c});
        check("d_res",      {16'd0, d_res},      {16'd0, mon_e.d});
        check("value_res",  value_res,           mon_e.val);
      end
    end
  end

  task automatic set_point(input logic [15:0] a, b, c, d);
    a_init = a; b_init = b; c_init = c; d_init = d;
  endtask

  task automatic set_diffs(input logic [15:0] a, b, c, d);
    sd_a = a; sd_b = b; sd_c = c; sd_d = d;
  endtask

  task automatic go();
    stub_launches = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_no_done: got no done in %0d cycles required done", name, n);
        break;
      end
    end
  endtask

  task automatic wait_step_starts(input string name, input int count);
    int seen, n;
    seen = 0; n = 0;
    while (seen < count) begin
      if (step_start) seen++;
      if (seen == count) break;
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_no_step: got %0d step_start required %0d", name, seen, count);
        break;
      end
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_step_start", {31'd0, step_start}, 32'd0);
    check("rst_status",     {30'd0, status},     32'd0);
    check("rst_iter",       {16'd0, iter_count}, 32'd0);
    check("rst_a_res",      {16'd0, a_res},      32'd0);
    check("rst_value",      value_res,           32'd0);
    rst_n = 1'b1;

    // 1: zero diffs converge after one step
    set_point(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    set_diffs(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    stub_val_base = 32'h1000_0000;
    sb_q.push_back('{2'b00, 16'd1, 16'h0100, 16'h0, 16'h0, 16'h0, 32'h1000_0001});
    go();
    @(negedge clk);
    check("step_start_latency", {31'd0, step_start}, 32'd1);
    check("busy_running",       {31'd0, busy},       32'd1);
    wait_done("c1");
    @(negedge clk);
    check("c1_busy_after", {31'd0, busy}, 32'd0);

    // 2: constant diff runs into the iteration limit
    set_point(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    set_diffs(16'h0010, 16'h0000, 16'h0000, 16'h0000);
    stub_val_base = 32'h2000_0000;
    sb_q.push_back('{2'b01, 16'd4, 16'h00C0, 16'h0, 16'h0, 16'h0, 32'h2000_0004});
    go();
    wait_done("c2");
    check("c2_launches", stub_launches, 32'd4);

    // 3: saturation at both rails, plus small diffs in c/d
    set_point(16'h8010, 16'h7FF0, 16'h0005, 16'hFFFF);
    set_diffs(16'h0040, 16'hFFC0, 16'h0001, 16'hFFFF);
    stub_val_base = 32'h3000_0000;
    sb_q.push_back('{2'b01, 16'd4, 16'h8000, 16'h7FFF, 16'h0001, 16'h0003, 32'h3000_0004});
    go();
    wait_step_starts("c3", 2);
    check("c3_sat_low_step1",  {16'd0, a_res}, 32'h0000_8000);
    check("c3_sat_high_step1", {16'd0, b_res}, 32'h0000_7FFF);
    wait_done("c3");

    // 4: overflow on the second step keeps the post-step-1 point
    set_point(16'h0100, 16'h0200, 16'h0000, 16'h0000);
    set_diffs(16'h0010, 16'hFFF0, 16'h0000, 16'h0000);
    stub_val_base = 32'h4000_0000;
    stub_ovf_at   = 2;
    sb_q.push_back('{2'b10, 16'd1, 16'h00F0, 16'h0210, 16'h0, 16'h0, 32'h4000_0001});
    go();
    wait_done("c4");
    stub_ovf_at = 0;

    // 5: silent step block times out; start during the run is ignored
    stub_silent = 1'b1;
    set_point(16'h0123, 16'h0000, 16'h0000, 16'h0000);
    sb_q.push_back('{2'b11, 16'd0, 16'h0123, 16'h0, 16'h0, 16'h0, 32'h4000_0001});
    go();
    wait_step_starts("c5", 1);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      if (done || n > 200) break;
    end
    check("c5_done_delay", n, 32'd64);
    @(negedge clk);
    check("c5_busy_after", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("c5_no_queued_start", {31'd0, busy}, 32'd0);
    check("c5_launches", stub_launches, 32'd1);
    stub_silent = 1'b0;

    // 6: asynchronous reset mid-wait, late step_done ignored, then a clean rerun
    set_point(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    set_diffs(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    stub_val_base = 32'h5000_0000;
    go();
    wait_step_starts("c6", 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c6_rst_busy",   {31'd0, busy},       32'd0);
    check("c6_rst_status", {30'd0, status},     32'd0);
    check("c6_rst_a_res",  {16'd0, a_res},      32'd0);
    check("c6_rst_value",  value_res,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("c6_idle_busy",  {31'd0, busy},  32'd0);
    check("c6_idle_a_res", {16'd0, a_res}, 32'd0);
    check("c6_idle_value", value_res,      32'd0);
    sb_q.push_back('{2'b00, 16'd1, 16'h0100, 16'h0, 16'h0, 16'h0, 32'h5000_0001});
    go();
    wait_done("c6");

    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gd_iter_ctrl.md
Name: gd_iter_ctrl

Overview:
Iteration sequencer for the 4-variable gradient-descent step datapath. It loads an initial point (a,b,c,d), repeatedly launches one gradient step, and applies the returned Q8.8 diffs with saturating subtraction. It stops on convergence, iteration limit, datapath overflow or watchdog timeout, then reports the final point, the function value and a status code. It sits between the top-level host/testbench and the gradient-step block.

Parameters:
MAX_ITER, 16'd256, maximum number of gradient steps before stopping (status 01); must be >= 1
TOL, 16'h0001, Q8.8 convergence tolerance; converged when |diff| <= TOL for all four diffs
TIMEOUT, 16'd1024, clk cycles allowed between step_start and step_done before abort (status 11)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin optimisation; sampled only in IDLE
a_init, b_init, c_init, d_init  in  16 each  signed Q8.8 initial point
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run ends
status  out  2  00 converged, 01 max-iter, 10 datapath overflow, 11 timeout; valid from done, held until next done
iter_count  out  16  completed (applied) steps in current/last run
a_res, b_res, c_res, d_res  out  16 each  signed Q8.8 current point; step operands
value_res  out  32  signed Q24.8 function value from last accepted step
step_start  out  1  one-cycle launch pulse to step block
step_a, step_b, step_c, step_d  out  16 each  operands to step block; wired to a_res..d_res
step_value  in  32  Q24.8 value from step block
step_a_diff, step_b_diff, step_c_diff, step_d_diff  in  16 each  signed Q8.8 diffs (learning rate already applied)
step_done  in  1  one-cycle result-valid pulse
step_overflow  in  1  overflow flag, sampled with step_done

Behaviour:
- Reset: state IDLE; all outputs, point regs, diff capture regs, timer and iter_count = 0; step_start = 0.
- States: IDLE, LOAD, STEP_REQ, STEP_WAIT, UPDATE, CHECK, DONE.
- IDLE: start=1 -> LOAD. start in any other state ignored (no queuing).
- LOAD: point regs <= *_init; iter_count <= 0; status unchanged -> STEP_REQ.
- STEP_REQ: step_start=1 (exactly this cycle); timer <= 0 -> STEP_WAIT.
- STEP_WAIT: timer increments each cycle. On step_done: if step_overflow -> status 10, DONE, point and iter_count not updated; else capture the four diffs and step_value into value_res -> UPDATE. Else if timer reaches TIMEOUT-1 -> status 11, DONE. step_done takes priority over a simultaneous timeout.
- UPDATE: x <= sat16(x - x_diff) per variable; 17-bit signed subtract, clamp to 0x7FFF / 0x8000; iter_count +1 -> CHECK.
- CHECK: all |diff| <= TOL (17-bit magnitude, so 0x8000 = 32768 > TOL) -> status 00, DONE; else iter_count == MAX_ITER -> status 01, DONE; else STEP_REQ. Convergence has priority over max-iter.
- DONE: done=1 for one cycle -> IDLE. Results hold until next LOAD.
- Step issue latency: start accepted (cycle 0) -> step_start high at cycle 2. From step_done to the next step_start: 3 cycles (UPDATE, CHECK, STEP_REQ). From step_done to done on final step: 3 cycles (UPDATE, CHECK, DONE).
- step_done while not in STEP_WAIT: ignored.
- Reset mid-run: immediate return to IDLE with all reset values; the step block is reset independently.

Test Plan:
1. Stub step block (latency 10) returns all diffs 0; a_init=0x0100 -> step_start at cycle 2; done with status 00, iter_count 1, a_res 0x0100, value_res = stub value.
2. MAX_ITER=4, TOL=1, stub returns a_diff=0x0010, others 0 -> status 01, iter_count 4, a_res 0x00C0, exactly 4 step_start pulses.
3. Saturation: a_init=0x8010 with a_diff=0x0040, b_init=0x7FF0 with b_diff=0xFFC0 -> a_res 0x8000, b_res 0x7FFF after step 1.
4. Stub asserts step_overflow with step_done on 2nd step -> status 10, iter_count 1, point equals post-step-1 values.
5. TIMEOUT=64, stub never responds -> done exactly 64 cycles after step_start, status 11, busy low the following cycle; start pulsed during the run has no effect.
6. rst_n low during STEP_WAIT -> all outputs 0 asynchronously; after release, new start runs case 1 correctly; a late step_done in IDLE is ignored.
